// File: rtl/iq_window_accumulator_if.sv
// Bundled readout-window signals: trigger and ADC sample stream in, packed
// I/Q window sums with status out.
interface iq_window_accumulator_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32
);
  logic                          trigger;
  logic                          adc_valid;
  logic signed [SAMPLE_WIDTH-1:0] adc_i;
  logic signed [SAMPLE_WIDTH-1:0] adc_q;
  logic [2*ACC_WIDTH-1:0]        accumulated_output;
  logic                          stb_start;
  logic                          busy;
  logic [1:0]                    sat_flags;
  logic                          trig_dropped;

  modport master (
    output trigger, adc_valid, adc_i, adc_q,
    input  accumulated_output, stb_start, busy, sat_flags, trig_dropped
  );

  modport slave (
    input  trigger, adc_valid, adc_i, adc_q,
    output accumulated_output, stb_start, busy, sat_flags, trig_dropped
  );
endinterface

// File: rtl/iq_window_accumulator.sv
// Triggered I/Q integrator: skips DELAY_LEN valid samples, then sums WINDOW_LEN
// valid samples per channel with saturation and presents {Q, I} with a strobe.
module iq_window_accumulator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int DELAY_LEN    = 0,
  parameter int WINDOW_LEN   = 500
) (
  input logic                   clk,
  input logic                   rst,
  iq_window_accumulator_if.slave bus
);

  localparam int CNT_MAX = (WINDOW_LEN > DELAY_LEN) ? WINDOW_LEN : DELAY_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = (DELAY_LEN > 0) ? CNT_W'(DELAY_LEN - 1) : '0;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    ACCUM   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACC_WIDTH-1:0]   acc_i_r, acc_q_r;
  logic                   sat_i_r, sat_q_r;
  logic [2*ACC_WIDTH-1:0] out_r;
  logic [1:0]             sat_out_r;
  logic                   stb_r, drop_r;
  logic [ACC_WIDTH:0]     sum_i_s, sum_q_s;

  // Returns {clamped, result}; overflow shows as disagreeing top two bits of the extended sum.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [SAMPLE_WIDTH-1:0] smp);
    logic [ACC_WIDTH:0] sum;
    sum = {acc[ACC_WIDTH-1], acc} +
          {{(ACC_WIDTH+1-SAMPLE_WIDTH){smp[SAMPLE_WIDTH-1]}}, smp};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      if (sum[ACC_WIDTH]) begin
        return {1'b1, ACC_MIN};
      end else begin
        return {1'b1, ACC_MAX};
      end
    end else begin
      return {1'b0, sum[ACC_WIDTH-1:0]};
    end
  endfunction

  // Saturating candidate sums for the current sample
  always_comb begin
    sum_i_s = sat_add(acc_i_r, bus.adc_i);
    sum_q_s = sat_add(acc_q_r, bus.adc_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; only valid samples advance the window
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.trigger) begin
          state_nxt_s = (DELAY_LEN > 0) ? HOLDOFF : ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLDOFF: begin
        if (bus.adc_valid && (cnt_r == DELAY_LAST)) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLDOFF;
        end
      end
      ACCUM: begin
        if (bus.adc_valid && (cnt_r == WINDOW_LAST)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counters, accumulators, sticky saturation and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      acc_i_r   <= '0;
      acc_q_r   <= '0;
      sat_i_r   <= 1'b0;
      sat_q_r   <= 1'b0;
      out_r     <= '0;
      sat_out_r <= 2'b00;
      stb_r     <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      stb_r  <= 1'b0;
      drop_r <= bus.trigger && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.trigger) begin
            cnt_r   <= '0;
            acc_i_r <= '0;
            acc_q_r <= '0;
            sat_i_r <= 1'b0;
            sat_q_r <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (bus.adc_valid) begin
            cnt_r <= (cnt_r == DELAY_LAST) ? '0 : cnt_r + CNT_ONE;
          end
        end
        ACCUM: begin
          if (bus.adc_valid) begin
            acc_i_r <= sum_i_s[ACC_WIDTH-1:0];
            acc_q_r <= sum_q_s[ACC_WIDTH-1:0];
            sat_i_r <= sat_i_r | sum_i_s[ACC_WIDTH];
            sat_q_r <= sat_q_r | sum_q_s[ACC_WIDTH];
            cnt_r   <= (cnt_r == WINDOW_LAST) ? '0 : cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          out_r     <= {acc_q_r, acc_i_r};
          sat_out_r <= {sat_q_r, sat_i_r};
          stb_r     <= 1'b1;
          cnt_r     <= '0;
          acc_i_r   <= '0;
          acc_q_r   <= '0;
          sat_i_r   <= 1'b0;
          sat_q_r   <= 1'b0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.accumulated_output = out_r;
  assign bus.sat_flags          = sat_out_r;
  assign bus.stb_start          = stb_r;
  assign bus.trig_dropped       = drop_r;
  assign bus.busy               = (state_r != IDLE);

endmodule

// File: tb/tb_iq_window_accumulator.sv
// Directed bench: three accumulator configurations driven with hand-computed
// windows covering holdoff, valid gaps, saturation, dropped triggers and reset.
module tb_iq_window_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int stb_cnt [3] = '{0, 0, 0};
  int drop_cnt [3] = '{0, 0, 0};
  logic [2:0] stb_vec, drop_vec;

  always #5 clk = ~clk;

  iq_window_accumulator_if #(.SAMPLE_WIDTH(16), .ACC_WIDTH(32)) a_if ();
  iq_window_accumulator_if #(.SAMPLE_WIDTH(16), .ACC_WIDTH(32)) b_if ();
  iq_window_accumulator_if #(.SAMPLE_WIDTH(16), .ACC_WIDTH(18)) c_if ();

  iq_window_accumulator #(.SAMPLE_WIDTH(16), .ACC_WIDTH(32), .DELAY_LEN(2), .WINDOW_LEN(4))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  iq_window_accumulator #(.SAMPLE_WIDTH(16), .ACC_WIDTH(32), .DELAY_LEN(0), .WINDOW_LEN(3))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  iq_window_accumulator #(.SAMPLE_WIDTH(16), .ACC_WIDTH(18), .DELAY_LEN(0), .WINDOW_LEN(8))
    dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  assign stb_vec  = {c_if.stb_start, b_if.stb_start, a_if.stb_start};
  assign drop_vec = {c_if.trig_dropped, b_if.trig_dropped, a_if.trig_dropped};

  // Count high cycles of each strobe and drop pulse
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      stb_cnt[k]  <= stb_cnt[k] + int'(stb_vec[k]);
      drop_cnt[k] <= drop_cnt[k] + int'(drop_vec[k]);
    end
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_stb(input int idx, input int budget, input string tag);
    int t;
    t = 0;
    while (!stb_vec[idx] && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_value(tag, 64'(stb_vec[idx]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base_s, base_d;
    logic busy_all;
    int   gi [7] = '{1, 1000, 1000, 2, 1000, 1000, 3};
    bit   gv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    a_if.trigger = 1'b0; a_if.adc_valid = 1'b0; a_if.adc_i = 16'sd0; a_if.adc_q = 16'sd0;
    b_if.trigger = 1'b0; b_if.adc_valid = 1'b0; b_if.adc_i = 16'sd0; b_if.adc_q = 16'sd0;
    c_if.trigger = 1'b0; c_if.adc_valid = 1'b0; c_if.adc_i = 16'sd0; c_if.adc_q = 16'sd0;

    repeat (2) @(negedge clk);
    check_value("rst_out", a_if.accumulated_output, 64'h0);
    check_value("rst_stb", 64'(a_if.stb_start), 64'd0);
    check_value("rst_busy", 64'(a_if.busy), 64'd0);
    check_value("rst_sat", 64'(a_if.sat_flags), 64'd0);
    check_value("rst_drop", 64'(a_if.trig_dropped), 64'd0);
    rst = 1'b0;

    // Basic window with holdoff
    base_s = stb_cnt[0];
    @(negedge clk); a_if.trigger = 1'b1; a_if.adc_valid = 1'b1; a_if.adc_i = 16'sd9999; a_if.adc_q = -16'sd50;
    @(negedge clk); check_value("t1_busy", 64'(a_if.busy), 64'd1); a_if.trigger = 1'b0;
    @(negedge clk);
    @(negedge clk); a_if.adc_i = 16'sd100;
    repeat (3) @(negedge clk);
    @(negedge clk); check_value("t1_no_early_stb", 64'(a_if.stb_start), 64'd0); a_if.adc_valid = 1'b0;
    @(negedge clk);
    check_value("t1_stb", 64'(a_if.stb_start), 64'd1);
    check_value("t1_out", a_if.accumulated_output, 64'hFFFFFF38_00000190);
    check_value("t1_sat", 64'(a_if.sat_flags), 64'd0);
    @(negedge clk);
    check_value("t1_stb_fall", 64'(a_if.stb_start), 64'd0);
    check_value("t1_idle", 64'(a_if.busy), 64'd0);
    repeat (2) @(negedge clk);
    check_value("t1_one_stb", 64'(stb_cnt[0] - base_s), 64'd1);
    check_value("t1_hold", a_if.accumulated_output, 64'hFFFFFF38_00000190);

    // Valid gaps, no holdoff
    busy_all = 1'b1;
    @(negedge clk); b_if.trigger = 1'b1; b_if.adc_valid = 1'b1; b_if.adc_i = 16'sd500; b_if.adc_q = 16'sd0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      busy_all = busy_all & b_if.busy;
      b_if.trigger = 1'b0;
      b_if.adc_valid = gv[n];
      b_if.adc_i = 16'(gi[n]);
    end
    @(negedge clk);
    busy_all = busy_all & b_if.busy;
    check_value("t2_no_early_stb", 64'(b_if.stb_start), 64'd0);
    b_if.adc_valid = 1'b0;
    @(negedge clk);
    check_value("t2_stb", 64'(b_if.stb_start), 64'd1);
    check_value("t2_out", b_if.accumulated_output, 64'h00000000_00000006);
    check_value("t2_busy_all", 64'(busy_all), 64'd1);

    // Saturation, then a clean window clears sat flags
    @(negedge clk); c_if.trigger = 1'b1; c_if.adc_valid = 1'b1; c_if.adc_i = 16'sd32767; c_if.adc_q = 16'h8000;
    @(negedge clk); c_if.trigger = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk); c_if.adc_valid = 1'b0;
    wait_stb(2, 4, "t3_stb");
    check_value("t3_out", 64'(c_if.accumulated_output), {28'h0, 18'h20000, 18'h1FFFF});
    check_value("t3_sat", 64'(c_if.sat_flags), 64'd3);
    c_if.trigger = 1'b1; c_if.adc_valid = 1'b1; c_if.adc_i = 16'sd1; c_if.adc_q = 16'sd0;
    @(negedge clk); c_if.trigger = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk); c_if.adc_valid = 1'b0;
    wait_stb(2, 4, "t3b_stb");
    check_value("t3b_out", 64'(c_if.accumulated_output), 64'h8);
    check_value("t3b_sat", 64'(c_if.sat_flags), 64'd0);

    // Dropped trigger mid-ACCUM
    base_s = stb_cnt[0];
    base_d = drop_cnt[0];
    @(negedge clk); a_if.trigger = 1'b1; a_if.adc_valid = 1'b1; a_if.adc_i = 16'sd100; a_if.adc_q = -16'sd50;
    @(negedge clk); a_if.trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); a_if.trigger = 1'b1;
    @(negedge clk); check_value("t4_drop", 64'(a_if.trig_dropped), 64'd1); a_if.trigger = 1'b0;
    @(negedge clk); check_value("t4_drop_fall", 64'(a_if.trig_dropped), 64'd0);
    @(negedge clk); a_if.adc_valid = 1'b0;
    wait_stb(0, 4, "t4_stb");
    check_value("t4_out", a_if.accumulated_output, 64'hFFFFFF38_00000190);
    repeat (3) @(negedge clk);
    check_value("t4_one_stb", 64'(stb_cnt[0] - base_s), 64'd1);
    check_value("t4_one_drop", 64'(drop_cnt[0] - base_d), 64'd1);

    // Asynchronous reset during ACCUM
    base_s = stb_cnt[0];
    @(negedge clk); a_if.trigger = 1'b1; a_if.adc_valid = 1'b1; a_if.adc_i = 16'sd100; a_if.adc_q = -16'sd50;
    @(negedge clk); a_if.trigger = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("t5_rst_out", a_if.accumulated_output, 64'h0);
    check_value("t5_rst_busy", 64'(a_if.busy), 64'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; a_if.adc_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_value("t5_no_stb", 64'(stb_cnt[0] - base_s), 64'd0);
    check_value("t5_out_kept0", a_if.accumulated_output, 64'h0);
    @(negedge clk); a_if.trigger = 1'b1; a_if.adc_valid = 1'b1; a_if.adc_i = 16'sd7; a_if.adc_q = 16'sd3;
    @(negedge clk); a_if.trigger = 1'b0;
    repeat (6) @(negedge clk);
    a_if.adc_valid = 1'b0;
    wait_stb(0, 4, "t5_stb");
    check_value("t5_out", a_if.accumulated_output, 64'h0000000C_0000001C);

    // Back-to-back: trigger in the strobe cycle
    @(negedge clk);
    base_d = drop_cnt[0];
    @(negedge clk); a_if.trigger = 1'b1; a_if.adc_valid = 1'b1; a_if.adc_i = 16'sd100; a_if.adc_q = -16'sd50;
    @(negedge clk); a_if.trigger = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    check_value("t6_stb1", 64'(a_if.stb_start), 64'd1);
    check_value("t6_out1", a_if.accumulated_output, 64'hFFFFFF38_00000190);
    a_if.trigger = 1'b1; a_if.adc_i = -16'sd3; a_if.adc_q = 16'sd5;
    @(negedge clk);
    check_value("t6_accepted", 64'(a_if.busy), 64'd1);
    a_if.trigger = 1'b0;
    wait_stb(0, 12, "t6_stb2");
    a_if.adc_valid = 1'b0;
    check_value("t6_out2", a_if.accumulated_output, 64'h00000014_FFFFFFF4);
    repeat (2) @(negedge clk);
    check_value("t6_no_drop", 64'(drop_cnt[0] - base_d), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
